// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM state codes,
// readdata flag positions and parity types.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Flag positions counted down from the MSB of avalon_readdata
  localparam int RD_VALID_OFS = 1;
  localparam int RD_OVR_OFS   = 2;
  localparam int RD_PERR_OFS  = 3;
  localparam int RD_FERR_OFS  = 4;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef struct packed {
    logic valid;
    logic ovr;
    logic perr;
    logic ferr;
  } rx_flags_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, parity/stop checks,
// one-entry holding register read through an Avalon-MM slave.
module uart_rx
  import uart_pkg::*;
#(
  parameter int    BYTESIZE = 8,
  parameter string PARITY   = "NONE",
  parameter int    STOPSIZE = 1,
  parameter int    N_BIT    = 8,
  parameter int    N_LOG    = $clog2(N_BIT),
  parameter int    ADW      = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           avalon_read,
  input  logic           avalon_write,
  input  logic [ADW-1:0] avalon_writedata,
  output logic [ADW-1:0] avalon_readdata,
  output logic           avalon_waitrequest,
  output logic           status_irq,
  output logic           status_err,
  input  logic           uart_rxd
);

  localparam int PAR_T = (PARITY == "EVEN") ? PAR_EVEN :
                         (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;
  localparam int CNT_W = $clog2(BYTESIZE);

  localparam logic [N_LOG-1:0] TMR_FULL = N_LOG'(N_BIT - 1);
  localparam logic [N_LOG-1:0] TMR_HALF = N_LOG'(N_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(BYTESIZE - 1);
  localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(STOPSIZE - 1);

  logic                rxd_m_q, rxd_s_q, rxd_p_q;
  logic [2:0]          state_q, state_d;
  logic [N_LOG-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTESIZE-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                perr_f_q, perr_f_d;
  logic                ferr_f_q, ferr_f_d;
  logic [BYTESIZE-1:0] data_q, data_d;
  rx_flags_t           flags_q, flags_d;

  logic fall, active, strobe, commit;
  logic unused_wdata;

  assign unused_wdata = ^avalon_writedata;

  // Edge detect runs on the synchronised line so every bit sees the same latency
  assign fall   = rxd_p_q & ~rxd_s_q;
  assign active = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign strobe = active && (tmr_q == '0);
  assign commit = (state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    perr_f_d = perr_f_q;
    ferr_f_d = ferr_f_q;
    if (active) tmr_d = strobe ? TMR_FULL : tmr_q - N_LOG'(1);
    case (state_q)
      ST_IDLE: if (fall) begin
        state_d  = ST_START;
        tmr_d    = TMR_HALF;
        par_d    = 1'b0;
        perr_f_d = 1'b0;
        ferr_f_d = 1'b0;
      end
      ST_START: if (strobe) begin
        state_d = rxd_s_q ? ST_IDLE : ST_DATA;
        cnt_d   = CNT_DATA;
      end
      ST_DATA: if (strobe) begin
        shift_d = {rxd_s_q, shift_q[BYTESIZE-1:1]};
        par_d   = par_q ^ rxd_s_q;
        if (cnt_q == '0) begin
          state_d = (PAR_T != PAR_NONE) ? ST_PARITY : ST_STOP;
          cnt_d   = CNT_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PARITY: if (strobe) begin
        perr_f_d = par_q ^ rxd_s_q ^ (PAR_T == PAR_ODD);
        state_d  = ST_STOP;
      end
      ST_STOP: if (strobe) begin
        if (!rxd_s_q) ferr_f_d = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register: an error-bearing commit beats a same-cycle write
  always_comb begin
    data_d  = data_q;
    flags_d = flags_q;
    if (avalon_read) flags_d.valid = 1'b0;
    if (avalon_write) begin
      flags_d.ovr  = 1'b0;
      flags_d.perr = 1'b0;
      flags_d.ferr = 1'b0;
    end
    if (commit) begin
      if (!flags_q.valid || avalon_read) begin
        data_d        = shift_q;
        flags_d.valid = 1'b1;
      end else begin
        flags_d.ovr = 1'b1;
      end
      if (perr_f_q) flags_d.perr = 1'b1;
      if (ferr_f_q) flags_d.ferr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m_q  <= 1'b1;
      rxd_s_q  <= 1'b1;
      rxd_p_q  <= 1'b1;
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      perr_f_q <= 1'b0;
      ferr_f_q <= 1'b0;
      data_q   <= '0;
      flags_q  <= '0;
    end else begin
      rxd_m_q  <= uart_rxd;
      rxd_s_q  <= rxd_m_q;
      rxd_p_q  <= rxd_s_q;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      perr_f_q <= perr_f_d;
      ferr_f_q <= ferr_f_d;
      data_q   <= data_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    avalon_readdata                   = '0;
    avalon_readdata[ADW-RD_VALID_OFS] = flags_q.valid;
    avalon_readdata[ADW-RD_OVR_OFS]   = flags_q.ovr;
    avalon_readdata[ADW-RD_PERR_OFS]  = flags_q.perr;
    avalon_readdata[ADW-RD_FERR_OFS]  = flags_q.ferr;
    avalon_readdata[BYTESIZE-1:0]     = data_q;
  end

  assign avalon_waitrequest = 1'b0;
  assign status_irq         = flags_q.valid;
  assign status_err         = flags_q.ovr | flags_q.perr | flags_q.ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: four receiver configurations driven by a serialising
// frame model, with a holding-register reference model per receiver.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rxd = '1, rd = '0, wr = '0;
  logic [3:0]  irq, err, wreq;
  logic [31:0] wdata = 32'hDEAD_BEEF;
  logic [31:0] rdata [4];

  int errs = 0, checks = 0;

  bit m_valid [4], m_ovr [4], m_perr [4], m_ferr [4];
  int m_data  [4];

  always #5 clk = ~clk;

  uart_rx #(.BYTESIZE(8), .PARITY("NONE"), .STOPSIZE(1), .N_BIT(8)) u0 (
    .clk(clk), .rst_n(rst_n), .avalon_read(rd[0]), .avalon_write(wr[0]),
    .avalon_writedata(wdata), .avalon_readdata(rdata[0]), .avalon_waitrequest(wreq[0]),
    .status_irq(irq[0]), .status_err(err[0]), .uart_rxd(rxd[0]));
  uart_rx #(.BYTESIZE(8), .PARITY("EVEN"), .STOPSIZE(1), .N_BIT(8)) u1 (
    .clk(clk), .rst_n(rst_n), .avalon_read(rd[1]), .avalon_write(wr[1]),
    .avalon_writedata(wdata), .avalon_readdata(rdata[1]), .avalon_waitrequest(wreq[1]),
    .status_irq(irq[1]), .status_err(err[1]), .uart_rxd(rxd[1]));
  uart_rx #(.BYTESIZE(8), .PARITY("ODD"), .STOPSIZE(2), .N_BIT(8)) u2 (
    .clk(clk), .rst_n(rst_n), .avalon_read(rd[2]), .avalon_write(wr[2]),
    .avalon_writedata(wdata), .avalon_readdata(rdata[2]), .avalon_waitrequest(wreq[2]),
    .status_irq(irq[2]), .status_err(err[2]), .uart_rxd(rxd[2]));
  uart_rx #(.BYTESIZE(7), .PARITY("NONE"), .STOPSIZE(2), .N_BIT(5)) u3 (
    .clk(clk), .rst_n(rst_n), .avalon_read(rd[3]), .avalon_write(wr[3]),
    .avalon_writedata(wdata), .avalon_readdata(rdata[3]), .avalon_waitrequest(wreq[3]),
    .status_irq(irq[3]), .status_err(err[3]), .uart_rxd(rxd[3]));

  // Per-receiver configuration: clocks/bit, data bits, parity (0 none,1 even,2 odd), stop bits
  function automatic int nt(int u); return (u == 3) ? 5 : 8; endfunction
  function automatic int nb(int u); return (u == 3) ? 7 : 8; endfunction
  function automatic int pm(int u); return (u == 1) ? 1 : (u == 2) ? 2 : 0; endfunction
  function automatic int ss(int u); return (u >= 2) ? 2 : 1; endfunction

  function automatic void m_reset();
    for (int u = 0; u < 4; u++) begin
      m_valid[u] = 0; m_ovr[u] = 0; m_perr[u] = 0; m_ferr[u] = 0; m_data[u] = 0;
    end
  endfunction

  function automatic void m_commit(int u, int d, bit pe, bit fe, bit rd_same);
    if (!m_valid[u] || rd_same) begin
      m_data[u]  = d & ((1 << nb(u)) - 1);
      m_valid[u] = 1;
    end else begin
      m_ovr[u] = 1;
    end
    if (pe) m_perr[u] = 1;
    if (fe) m_ferr[u] = 1;
  endfunction

  function automatic logic [31:0] m_rdata(int u);
    logic [31:0] r;
    r     = 32'(m_data[u]);
    r[31] = m_valid[u];
    r[30] = m_ovr[u];
    r[29] = m_perr[u];
    r[28] = m_ferr[u];
    return r;
  endfunction

  function automatic logic m_err(int u);
    return m_ovr[u] | m_perr[u] | m_ferr[u];
  endfunction

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(int u);
    @(negedge clk); rd[u] = 1'b1;
    @(negedge clk); rd[u] = 1'b0;
    m_valid[u] = 0;
  endtask

  task automatic do_write(int u);
    @(negedge clk); wr[u] = 1'b1; wdata = $urandom;
    @(negedge clk); wr[u] = 1'b0;
    m_ovr[u] = 0; m_perr[u] = 0; m_ferr[u] = 0;
  endtask

  // Serialise one frame; rd_done pulses read during the receiver's commit cycle
  // (mid last stop bit + sync latency + one cycle, valid for 8 clocks/bit)
  task automatic send_frame(int u, int d, bit flip_par, bit stop_v, bit rd_done);
    logic bits [$];
    bit   p = 0, pe = 0;
    int   klast, n;
    n = nt(u);
    bits.push_back(1'b0);
    for (int i = 0; i < nb(u); i++) begin
      bits.push_back(d[i]);
      p ^= d[i];
    end
    if (pm(u) != 0) begin
      bits.push_back(((pm(u) == 1) ? p : !p) ^ flip_par);
      pe = flip_par;
    end
    for (int s = 0; s < ss(u); s++) bits.push_back(stop_v);
    klast = bits.size() - 1;
    for (int c = 0; c < bits.size() * n; c++) begin
      @(negedge clk);
      rxd[u] = bits[c / n];
      rd[u]  = rd_done && (c == 3 + n / 2 + n * klast);
    end
    @(negedge clk);
    rxd[u] = 1'b1;
    rd[u]  = 1'b0;
    m_commit(u, d, pe, !stop_v, rd_done);
  endtask

  task automatic test_reset();
    idle(3);
    m_reset();
    for (int u = 0; u < 4; u++) begin
      checks++; if (rdata[u] !== 32'h0) begin errs++; $display("FAIL reset_rdata u%0d: got %h want 0", u, rdata[u]); end
      checks++; if (irq[u] !== 1'b0) begin errs++; $display("FAIL reset_irq u%0d: got %b want 0", u, irq[u]); end
      checks++; if (err[u] !== 1'b0) begin errs++; $display("FAIL reset_err u%0d: got %b want 0", u, err[u]); end
      checks++; if (wreq[u] !== 1'b0) begin errs++; $display("FAIL waitrequest u%0d: got %b want 0", u, wreq[u]); end
    end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_frame();
    send_frame(0, 8'hA5, 0, 1, 0); idle(3);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL frame_a5 rdata: got %h want %h", rdata[0], m_rdata(0)); end
    checks++; if (irq[0] !== 1'b1) begin errs++; $display("FAIL frame_a5 irq: got %b want 1", irq[0]); end
    checks++; if (err[0] !== 1'b0) begin errs++; $display("FAIL frame_a5 err: got %b want 0", err[0]); end
    do_read(0);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL frame_a5 after read: got %h want %h", rdata[0], m_rdata(0)); end
    checks++; if (irq[0] !== 1'b0) begin errs++; $display("FAIL frame_a5 irq after read: got %b want 0", irq[0]); end
  endtask

  task automatic test_glitch();
    @(negedge clk); rxd[0] = 1'b0;
    idle(2);
    @(negedge clk); rxd[0] = 1'b1;
    idle(20);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL glitch rdata: got %h want %h", rdata[0], m_rdata(0)); end
    checks++; if ({irq[0], err[0]} !== 2'b00) begin errs++; $display("FAIL glitch irq/err: got %b want 00", {irq[0], err[0]}); end
    send_frame(0, 8'h96, 0, 1, 0); idle(3);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL glitch rearm: got %h want %h", rdata[0], m_rdata(0)); end
    do_read(0);
  endtask

  task automatic test_ferr();
    send_frame(0, 8'h3C, 0, 0, 0); idle(3);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL ferr rdata: got %h want %h", rdata[0], m_rdata(0)); end
    checks++; if ({irq[0], err[0]} !== 2'b11) begin errs++; $display("FAIL ferr irq/err: got %b want 11", {irq[0], err[0]}); end
    do_write(0);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL ferr after write: got %h want %h", rdata[0], m_rdata(0)); end
    checks++; if (err[0] !== 1'b0) begin errs++; $display("FAIL ferr err after write: got %b want 0", err[0]); end
    do_read(0);
  endtask

  task automatic test_parity();
    send_frame(1, 8'h01, 1, 1, 0); idle(3);
    checks++; if (rdata[1] !== m_rdata(1)) begin errs++; $display("FAIL parity_bad rdata: got %h want %h", rdata[1], m_rdata(1)); end
    checks++; if (err[1] !== 1'b1) begin errs++; $display("FAIL parity_bad err: got %b want 1", err[1]); end
    do_read(1); do_write(1);
    send_frame(1, 8'h01, 0, 1, 0); idle(3);
    checks++; if (rdata[1] !== m_rdata(1)) begin errs++; $display("FAIL parity_good rdata: got %h want %h", rdata[1], m_rdata(1)); end
    checks++; if (err[1] !== 1'b0) begin errs++; $display("FAIL parity_good err: got %b want 0", err[1]); end
    do_read(1);
  endtask

  task automatic test_back_to_back();
    send_frame(0, 8'h11, 0, 1, 0);
    send_frame(0, 8'h22, 0, 1, 0); idle(3);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL overrun rdata: got %h want %h", rdata[0], m_rdata(0)); end
    checks++; if (err[0] !== 1'b1) begin errs++; $display("FAIL overrun err: got %b want 1", err[0]); end
    do_read(0); do_write(0);
    send_frame(0, 8'h11, 0, 1, 0);
    send_frame(0, 8'h22, 0, 1, 1); idle(3);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL read_in_done rdata: got %h want %h", rdata[0], m_rdata(0)); end
    checks++; if ({irq[0], err[0]} !== 2'b10) begin errs++; $display("FAIL read_in_done irq/err: got %b want 10", {irq[0], err[0]}); end
    do_read(0);
  endtask

  task automatic test_break();
    @(negedge clk); rxd[0] = 1'b0;
    idle(240);
    @(negedge clk); rxd[0] = 1'b1;
    m_commit(0, 0, 0, 1, 0);
    idle(20);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL break rdata: got %h want %h", rdata[0], m_rdata(0)); end
    checks++; if ({irq[0], err[0]} !== 2'b11) begin errs++; $display("FAIL break irq/err: got %b want 11", {irq[0], err[0]}); end
    do_read(0); do_write(0);
  endtask

  task automatic test_midreset();
    send_frame(0, 8'h77, 0, 1, 0); idle(3);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL pre_reset rdata: got %h want %h", rdata[0], m_rdata(0)); end
    for (int c = 0; c < 40; c++) begin @(negedge clk); rxd[0] = 1'b0; end
    @(negedge clk); rst_n = 1'b0; rxd[0] = 1'b1;
    m_reset();
    @(negedge clk);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL in_reset rdata: got %h want %h", rdata[0], m_rdata(0)); end
    @(negedge clk); rst_n = 1'b1;
    idle(10);
    send_frame(0, 8'h5A, 0, 1, 0); idle(3);
    checks++; if (rdata[0] !== m_rdata(0)) begin errs++; $display("FAIL post_reset rdata: got %h want %h", rdata[0], m_rdata(0)); end
    checks++; if ({irq[0], err[0]} !== 2'b10) begin errs++; $display("FAIL post_reset irq/err: got %b want 10", {irq[0], err[0]}); end
    do_read(0);
  endtask

  task automatic test_loopback();
    int  d;
    bit  fp, sv, rdd;
    for (int u = 0; u < 4; u++) begin
      for (int i = 0; i < 64; i++) begin
        d   = $urandom & ((1 << nb(u)) - 1);
        fp  = (pm(u) != 0) && ($urandom_range(0, 7) == 0);
        sv  = ($urandom_range(0, 7) != 0);
        rdd = (nt(u) >= 8) && ($urandom_range(0, 3) == 0);
        send_frame(u, d, fp, sv, rdd);
        idle($urandom_range(3, 6));
        checks++; if (rdata[u] !== m_rdata(u)) begin errs++; $display("FAIL loop u%0d #%0d rdata: got %h want %h", u, i, rdata[u], m_rdata(u)); end
        checks++; if ({irq[u], err[u]} !== {m_valid[u], m_err(u)}) begin errs++; $display("FAIL loop u%0d #%0d irq/err: got %b want %b", u, i, {irq[u], err[u]}, {m_valid[u], m_err(u)}); end
        if ($urandom_range(0, 3) != 0) do_read(u);
        if ($urandom_range(0, 7) == 0) do_write(u);
      end
      do_read(u); do_write(u);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: no finish after time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_glitch();
    test_ferr();
    test_parity();
    test_back_to_back();
    test_break();
    test_midreset();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
